// File: rtl/dbg_pkg.sv
// Shared encodings for the debug push-button controller.
package dbg_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESSED   = 2'd1,
      S_LONG_WAIT = 2'd2
   } state_t;

   localparam logic MODE_STEP = 1'b0;
   localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/dbg_debounce.sv
// Two-flop synchroniser plus stable-sample debounce for an active-low button.
module dbg_debounce
   import dbg_pkg::*;
#(
   parameter int DB_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_btn_db
);

   localparam int DW = $clog2(DB_CYCLES);
   localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [DW-1:0] db_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], i_btn};
   end

   // Level is accepted only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         db_cnt   <= '0;
         o_btn_db <= 1'b1;
      end else if (sync_q[1] != o_btn_db) begin
         if (db_cnt == DB_MAX) begin
            o_btn_db <= sync_q[1];
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

endmodule

// File: rtl/dbg_button_ctrl.sv
// Button-driven processor clock-enable: short press = step, long press = RUN/STEP toggle.
// Optional DBG_BTN_HALT_STOP_EN: a HALT rising edge in RUN mode drops back to STEP.
module dbg_button_ctrl
   import dbg_pkg::*;
#(
   parameter int DB_CYCLES   = 250000,
   parameter int LONG_CYCLES = 25000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_btn,
   input  logic       i_halted,
   output logic       o_run_en,
   output logic       o_step_pulse,
   output logic       o_mode,
   output logic       o_btn_db,
   output logic [7:0] o_press_cnt
);

   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          short_evt, long_evt, halt_clr, pulse_nxt, mode_nxt;

   dbg_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_btn    (i_btn),
      .o_btn_db (o_btn_db)
   );

`ifdef DBG_BTN_HALT_STOP_EN
   logic halted_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) halted_q <= 1'b0;
      else          halted_q <= i_halted;
   end

   assign halt_clr = (o_mode == MODE_RUN) && i_halted && !halted_q;
`else
   assign halt_clr = 1'b0;
`endif

   // Release and long-hold are exclusive because both are decided in S_PRESSED.
   assign short_evt = (state == S_PRESSED) && o_btn_db;
   assign long_evt  = (state == S_PRESSED) && !o_btn_db && (hold_cnt == HOLD_MAX);
   assign pulse_nxt = short_evt && (o_mode == MODE_STEP) && !i_halted;
   assign mode_nxt  = halt_clr ? MODE_STEP : (long_evt ? ~o_mode : o_mode);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         hold_cnt     <= '0;
         o_mode       <= MODE_STEP;
         o_step_pulse <= 1'b0;
         o_run_en     <= 1'b0;
         o_press_cnt  <= 8'd0;
      end else begin
         o_mode       <= mode_nxt;
         o_step_pulse <= pulse_nxt;
         o_run_en     <= (mode_nxt & ~i_halted) | pulse_nxt;
         if (short_evt) o_press_cnt <= o_press_cnt + 8'd1;
         case (state)
            S_IDLE: begin
               if (!o_btn_db) begin
                  state    <= S_PRESSED;
                  hold_cnt <= '0;
               end
            end
            S_PRESSED: begin
               if (o_btn_db)                   state    <= S_IDLE;
               else if (hold_cnt == HOLD_MAX)  state    <= S_LONG_WAIT;
               else                            hold_cnt <= hold_cnt + 1'b1;
            end
            S_LONG_WAIT: begin
               if (o_btn_db) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dbg_button_ctrl.md
Name: dbg_button_ctrl

Overview:
- Input-side debug controller for the FPGA load-processor bring-up. It is the complement of the LED state display: that display shows processor state out, and this block takes an operator push-button in.
- Synchronises and debounces a raw active-low board button, then classifies each press as short or long.
- Drives the processor clock-enable: free-run mode, or one instruction-cycle step per short press.
- Sits between the board pin and the processor core, inside the FPGA top level.

Parameters:
- DB_CYCLES, default 250000: consecutive stable synchronised samples required to accept a level change (10 ms at 25 MHz).
- LONG_CYCLES, default 25000000: debounced-press duration that counts as a long press (1 s).
- Counter widths are derived with $clog2 of each parameter. Legal range: DB_CYCLES ≥ 2, LONG_CYCLES > DB_CYCLES.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_btn  in  1  raw button, active-low, asynchronous to i_clk
- i_halted  in  1  processor reports HALT state
- o_run_en  out  1  processor clock-enable
- o_step_pulse  out  1  single-cycle step strobe
- o_mode  out  1  0 = STEP, 1 = RUN
- o_btn_db  out  1  debounced button level, active-low
- o_press_cnt  out  8  count of accepted short presses

Behaviour:
- Reset (async assert, sync release) values:
  - o_run_en = 0, o_step_pulse = 0, o_mode = 0 (STEP), o_press_cnt = 0, o_btn_db = 1.
  - Synchroniser flops = 1, all counters = 0, FSM = S_IDLE.
- Synchroniser: two flops on i_btn. No logic between the flops.
- Debounce:
  - db_cnt increments on each cycle where sync_out ≠ o_btn_db, and clears to 0 on any cycle where they are equal.
  - When db_cnt == DB_CYCLES-1 and the inputs still differ, o_btn_db toggles on that edge and db_cnt clears.
  - Any glitch shorter than DB_CYCLES cycles is ignored.
- FSM states: S_IDLE, S_PRESSED, S_LONG_WAIT.
  - S_IDLE: on o_btn_db falling (1→0), go to S_PRESSED and clear hold_cnt.
  - S_PRESSED: hold_cnt increments every cycle and saturates.
    - If o_btn_db rises before hold_cnt reaches LONG_CYCLES-1, this is a short press. Return to S_IDLE and do the short-press action on the next cycle.
    - If hold_cnt reaches LONG_CYCLES-1 while the button is still pressed, toggle o_mode on that edge and go to S_LONG_WAIT. The toggle happens while the button is held, not on release.
  - S_LONG_WAIT: wait for o_btn_db to rise, then go to S_IDLE with no further action.
- Short-press action:
  - In STEP mode with i_halted == 0: o_step_pulse high for exactly 1 cycle, and o_press_cnt increments.
  - In RUN mode or with i_halted == 1: no pulse, but o_press_cnt still increments.
  - o_press_cnt wraps 255 → 0.
- o_run_en is registered and equals (o_mode & ~i_halted) | o_step_pulse. It changes in the same cycle as o_step_pulse / o_mode.
- Latency: a clean raw release edge gives o_step_pulse in cycle DB_CYCLES+3 after the edge, with tolerance +1 for sampling phase.
- Simultaneous events: a mode toggle and a short press cannot coincide, because the FSM makes them exclusive.
- Reset mid-press: all state is lost and the FSM returns to S_IDLE. A button still held after reset release is debounced as a fresh press.

Optional Feature:
- Macro: DBG_BTN_HALT_STOP_EN.
- Defined: in RUN mode, a 0→1 edge on i_halted (edge detected via a registered copy) forces o_mode to 0 on the next cycle. If it coincides with a long-press toggle, the forced clear wins.
- Undefined: i_halted only gates o_run_en and step pulses. o_mode is unaffected.

Decomposition:
- Package dbg_pkg:
  - FSM state localparams: S_IDLE = 2'd0, S_PRESSED = 2'd1, S_LONG_WAIT = 2'd2.
  - Mode encodings: MODE_STEP = 1'b0, MODE_RUN = 1'b1.
- Sub-module dbg_debounce: synchroniser plus debounce counter, parameter DB_CYCLES, output o_btn_db. The top level holds the FSM, hold counter, mode register and outputs.

Test Plan (bench overrides DB_CYCLES = 4, LONG_CYCLES = 20):
- Button low for 3 cycles, then high → o_btn_db stays 1, and no pulse, mode change or count change occurs.
- Button low for 10 cycles, then high, in STEP mode with i_halted = 0 → exactly one o_step_pulse, o_run_en high for that cycle only, o_press_cnt = 1, pulse at cycle 7 (+1) after the raw release.
- Button held for 40 cycles → o_mode goes 0 → 1 while held, with no step pulse. After release, o_run_en = 1 continuously. Hold again for 40 cycles → o_mode = 0.
- RUN mode, raise i_halted → o_run_en drops 1 cycle later. With DBG_BTN_HALT_STOP_EN, o_mode = 0; without it, o_mode stays 1.
- 256 short presses → o_press_cnt wraps to 0. A short press in STEP mode with i_halted = 1 → no pulse, count still increments.
- Assert i_rst_n low in the middle of a long hold → all outputs return to reset values immediately. Button still low at release → new press is accepted after DB_CYCLES.
